// File: rtl/node_sequencer.sv
// node_sequencer: runs one CLEAR/ACCUM/CAPTURE inner-product pass per input frame
// and holds each result in a valid/ready slice. Define NODE_SEQ_PERF_EN for frame_cnt.
//   state   | meaning
//   IDLE    | waiting for in_valid, node accumulator held
//   CLEAR   | node accumulator cleared, first product loaded
//   ACCUM   | IMAGE_SIZE accumulate cycles (cnt 1..IMAGE_SIZE)
//   CAPTURE | result loaded into slice and frame acked; stalls while slice is full
module node_sequencer #(
  parameter int IMAGE_SIZE = 64,
  parameter int CNT_W      = 7,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ack,
  output logic              start,
  output logic              reset_acc,
  output logic [CNT_W-1:0]  cnt_val,
  input  logic [DATA_W-1:0] node_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
`ifdef NODE_SEQ_PERF_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, CAPTURE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(IMAGE_SIZE);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             take;

  // The slice can accept a new result if it is empty or being drained this cycle.
  assign take      = (state == CAPTURE) && (!out_valid || out_ready);
  assign in_ack    = take;
  assign start     = (state != ACCUM);
  assign reset_acc = (state == CLEAR);
  assign cnt_val   = (state == ACCUM && cnt != LAST) ? cnt : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid)
            state <= CLEAR;
        end
        CLEAR: begin
          cnt   <= CNT_W'(1);
          state <= ACCUM;
        end
        ACCUM: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          if (take) begin
            out_data  <= node_out;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NODE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      frame_cnt <= '0;
    else if (take && frame_cnt != 16'hFFFF)
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule
